// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared definitions for the round-robin multiplier scheduler.
//   DEF_DATA_W / DEF_MUL_LATENCY : default operand width and pipeline depth
//   mul_tag_t                    : operand/tag bundle for the default configuration
//   rr_pick()                    : round-robin winner search starting at ptr
package mult_sched_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MUL_LATENCY = 3;
  localparam int DEF_ID_W        = 2;
  // Widest request vector rr_pick can search.
  localparam int MAX_REQ         = 32;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
  } mul_tag_t;

  // First asserted bit of vld[n-1:0] at or after ptr, wrapping modulo n.
  // Returns ptr when nothing is asserted; callers gate with |vld.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] vld,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n && !found) begin
        // ptr < n and i < n, so one conditional subtract is a full modulo.
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (vld[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// mult_pipe: fixed-latency unsigned multiplier, full 2*DATA_W product.
// The product is formed at the input and registered into stage 1; valid and
// ID ride alongside through MUL_LATENCY register stages. Never stalls.
//   clk_i, rst_i       : clock, async active-high reset
//   in_vld_i/id/a/b    : issue slot (one op per cycle max)
//   stage_vld_o        : valid bit of every stage (for credit counting)
//   out_vld/id/prod_o  : last stage, written into the result FIFO next edge
module mult_pipe
  import mult_sched_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int ID_W        = DEF_ID_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_vld_i,
  input  logic [ID_W-1:0]        in_id_i,
  input  logic [DATA_W-1:0]      in_a_i,
  input  logic [DATA_W-1:0]      in_b_i,
  output logic [MUL_LATENCY-1:0] stage_vld_o,
  output logic                   out_vld_o,
  output logic [ID_W-1:0]        out_id_o,
  output logic [2*DATA_W-1:0]    out_prod_o
);

  logic [MUL_LATENCY:1]                 vld_pipe_q;
  logic [MUL_LATENCY:1][ID_W-1:0]       id_q;
  logic [MUL_LATENCY:1][2*DATA_W-1:0]   prod_q;
  logic [2*DATA_W-1:0]                  prod_d;

  // Zero-extend both operands so the multiply is sized to the full product.
  assign prod_d = {{DATA_W{1'b0}}, in_a_i} * {{DATA_W{1'b0}}, in_b_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe_q <= '0;
      id_q       <= '0;
      prod_q     <= '0;
    end else begin
      vld_pipe_q[1] <= in_vld_i;
      id_q[1]       <= in_id_i;
      prod_q[1]     <= prod_d;
      for (int s = 2; s <= MUL_LATENCY; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        id_q[s]       <= id_q[s-1];
        prod_q[s]     <= prod_q[s-1];
      end
    end
  end

  assign stage_vld_o = vld_pipe_q;
  assign out_vld_o   = vld_pipe_q[MUL_LATENCY];
  assign out_id_o    = id_q[MUL_LATENCY];
  assign out_prod_o  = prod_q[MUL_LATENCY];

endmodule

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: NUM_REQ requesters share one pipelined multiplier.
// Round-robin grant, credit-based issue (pipeline + FIFO occupancy bounded by
// FIFO_DEPTH), ID-tagged results returned in issue order through a FIFO.
//   ACLK, ARESET          : clock, async active-high reset
//   req_valid/a/b         : per-requester operands, packed i*DATA_W
//   req_ready             : one-hot (or zero) grant
//   rsp_valid/ready/data/id : result channel at FIFO head
//   busy                  : anything in pipeline or FIFO
// Optional: define MULT_RR_SCHEDULER_STATS_EN for grant_cnt / stall_cnt ports
// (saturating 32-bit counters).
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = DEF_DATA_W,
  parameter  int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter  int FIFO_DEPTH  = 4,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]           rsp_id,
`ifdef MULT_RR_SCHEDULER_STATS_EN
  output logic [NUM_REQ*32-1:0]     grant_cnt,
  output logic [31:0]               stall_cnt,
`endif
  output logic                      busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [NUM_REQ-1:0][DATA_W-1:0] a_v, b_v;
  logic [ID_W-1:0]                ptr_q, ptr_d, winner;
  logic                           any_vld, can_issue, hs;
  int unsigned                    in_flight;

  logic [MUL_LATENCY-1:0]         pipe_vld;
  logic                           push;
  logic [ID_W-1:0]                push_id;
  logic [2*DATA_W-1:0]            push_prod;
  logic                           pop;

  logic [2*DATA_W-1:0]            mem_q    [FIFO_DEPTH];
  logic [ID_W-1:0]                id_mem_q [FIFO_DEPTH];
  logic [PW-1:0]                  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                  cnt_q;

  assign a_v = req_a;
  assign b_v = req_b;

  // Credit is taken from registered state only, so a pop this cycle frees
  // its slot one cycle later and the FIFO can never be pushed while full.
  always_comb begin
    in_flight = 32'(cnt_q);
    for (int s = 0; s < MUL_LATENCY; s++) in_flight += 32'(pipe_vld[s]);
  end

  assign can_issue = (in_flight < 32'(FIFO_DEPTH));
  assign busy      = (in_flight != 0);
  assign any_vld   = |req_valid;
  assign winner    = ID_W'(rr_pick(MAX_REQ'(req_valid), 32'(ptr_q), NUM_REQ));
  assign hs        = any_vld & can_issue;

  always_comb begin
    req_ready = '0;
    if (any_vld) req_ready[winner] = can_issue;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  mult_pipe #(
    .DATA_W      (DATA_W),
    .MUL_LATENCY (MUL_LATENCY),
    .ID_W        (ID_W)
  ) u_pipe (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .in_vld_i    (hs),
    .in_id_i     (winner),
    .in_a_i      (a_v[winner]),
    .in_b_i      (b_v[winner]),
    .stage_vld_o (pipe_vld),
    .out_vld_o   (push),
    .out_id_o    (push_id),
    .out_prod_o  (push_prod)
  );

  // Result FIFO. Storage is reset so the head reads zero out of reset; the
  // head slot is never written while occupied, so outputs hold under stall.
  assign pop = rsp_valid & rsp_ready;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]    <= '0;
        id_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q]    <= push_prod;
        id_mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rsp_valid = (cnt_q != '0);
  assign rsp_data  = mem_q[rd_ptr_q];
  assign rsp_id    = id_mem_q[rd_ptr_q];

`ifdef MULT_RR_SCHEDULER_STATS_EN
  logic [NUM_REQ-1:0][31:0] gcnt_q;
  logic [31:0]              stall_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      gcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (hs && 32'(winner) == i && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + 1'b1;
      if (any_vld && !can_issue && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign grant_cnt = gcnt_q;
  assign stall_cnt = stall_q;
`endif

endmodule
